mdio_slave_22_45_backend: RTL and testbench

MDIO_SLAVE_22_45_BACKEND -- requirements
Module: mdio_slave_22_45_backend

---
 rtl/mdio_slave_22_45_backend.sv | 165 ++++++++++++++++
 tb/tb_mdio_slave_22_45_backend.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave_22_45_backend.sv
// MDIO slave backend: decodes Clause 22/45 frames from the frontend and drives a
// simple register bus, with ack timeout, C45 address/post-increment and a one-deep read queue.
module mdio_slave_22_45_backend #(
  parameter int unsigned TIMEOUT = 12
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] req_data,
  input  logic        req_phyaddr_done,
  input  logic        req_regaddr_done,
  input  logic        req_frame_done,
  input  logic        legal,
  output logic [15:0] resp_rdata,
  output logic        resp_ready,
  output logic        reg_req,
  output logic        reg_wr,
  output logic        reg_c45,
  output logic [4:0]  reg_devad,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack,
  output logic        err_timeout
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  typedef enum logic [1:0] {K_NONE, K_READ, K_WRITE, K_ADDR} kind_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   c45_addr;
  logic [4:0]    c45_devad;
  logic          pend_valid;
  logic [13:0]   pend_hdr;
  logic          rd_inc;

  // Header layout: [13:12] ST, [11:10] OP, [9:5] PHYAD, [4:0] REGAD/DEVAD.
  function automatic kind_t hdr_kind(input logic [13:0] h);
    unique case (h[13:10])
      4'b0110, 4'b0011, 4'b0010: hdr_kind = K_READ;
      4'b0101, 4'b0001:          hdr_kind = K_WRITE;
      4'b0000:                   hdr_kind = K_ADDR;
      default:                   hdr_kind = K_NONE;
    endcase
  endfunction

  logic [13:0] req_hdr;
  logic [13:0] iss_hdr;
  logic        rd_ev, wr_ev, addr_ev;
  logic        iss_c45, req_c45;

  assign req_hdr = req_data[31:18];
  assign rd_ev   = legal && req_regaddr_done && (hdr_kind(req_hdr) == K_READ);
  assign wr_ev   = legal && req_frame_done   && (hdr_kind(req_hdr) == K_WRITE);
  assign addr_ev = legal && req_frame_done   && (hdr_kind(req_hdr) == K_ADDR);
  // A fresh read event takes precedence over a queued one.
  assign iss_hdr = rd_ev ? req_hdr : pend_hdr;
  assign iss_c45 = (iss_hdr[13:12] == 2'b00);
  assign req_c45 = (req_hdr[13:12] == 2'b00);

  logic unused_bits;
  assign unused_bits = ^{req_data[17:16], c45_devad};

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      c45_addr    <= '0;
      c45_devad   <= '0;
      pend_valid  <= 1'b0;
      pend_hdr    <= '0;
      rd_inc      <= 1'b0;
      reg_req     <= 1'b0;
      reg_wr      <= 1'b0;
      reg_c45     <= 1'b0;
      reg_devad   <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      resp_rdata  <= '1;
      resp_ready  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        reg_req    <= 1'b0;
        pend_valid <= 1'b0;
        resp_ready <= 1'b0;
      end else begin
        if (req_phyaddr_done) begin
          resp_ready <= 1'b0;
          resp_rdata <= '1;
        end
        unique case (state)
          IDLE: begin
            if (rd_ev || pend_valid) begin
              reg_req    <= 1'b1;
              reg_wr     <= 1'b0;
              reg_c45    <= iss_c45;
              reg_devad  <= iss_c45 ? iss_hdr[4:0] : iss_hdr[9:5];
              reg_addr   <= iss_c45 ? c45_addr : {11'b0, iss_hdr[4:0]};
              rd_inc     <= (iss_hdr[13:10] == 4'b0010);
              pend_valid <= 1'b0;
              cnt        <= '0;
              state      <= RD_WAIT;
            end else if (wr_ev) begin
              reg_req   <= 1'b1;
              reg_wr    <= 1'b1;
              reg_c45   <= req_c45;
              reg_devad <= req_c45 ? req_hdr[4:0] : req_hdr[9:5];
              reg_addr  <= req_c45 ? c45_addr : {11'b0, req_hdr[4:0]};
              reg_wdata <= req_data[15:0];
              cnt       <= '0;
              state     <= WR_WAIT;
            end
          end
          RD_WAIT: begin
            if (reg_ack) begin
              resp_rdata <= reg_rdata;
              resp_ready <= 1'b1;
              reg_req    <= 1'b0;
              state      <= IDLE;
              if (rd_inc) c45_addr <= c45_addr + 16'd1;
            end else if (cnt == CNT_LAST) begin
              resp_rdata  <= '1;
              resp_ready  <= 1'b1;
              reg_req     <= 1'b0;
              err_timeout <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          WR_WAIT: begin
            if (rd_ev) begin
              pend_valid <= 1'b1;
              pend_hdr   <= req_hdr;
            end
            if (reg_ack) begin
              reg_req <= 1'b0;
              state   <= IDLE;
            end else if (cnt == CNT_LAST) begin
              reg_req     <= 1'b0;
              err_timeout <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
        // An address frame may arrive while a bus access is still outstanding.
        if (addr_ev) begin
          c45_addr  <= req_data[15:0];
          c45_devad <= req_data[22:18];
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave_22_45_backend.sv
// Bench for mdio_slave_22_45_backend: literal vector table, hand-written corner
// sequences, then random frames checked against a transaction-level model.
module tb_mdio_slave_22_45_backend;

  localparam int TIMEOUT = 12;

  logic        clk_25m, rst_n, enable;
  logic [31:0] req_data;
  logic        req_phyaddr_done, req_regaddr_done, req_frame_done, legal;
  logic [15:0] resp_rdata;
  logic        resp_ready;
  logic        reg_req, reg_wr, reg_c45;
  logic [4:0]  reg_devad;
  logic [15:0] reg_addr, reg_wdata, reg_rdata;
  logic        reg_ack, err_timeout;

  int checks = 0;
  int failures = 0;
  logic [15:0] c45_m;

  mdio_slave_22_45_backend #(.TIMEOUT(TIMEOUT)) dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .enable(enable), .req_data(req_data),
    .req_phyaddr_done(req_phyaddr_done), .req_regaddr_done(req_regaddr_done),
    .req_frame_done(req_frame_done), .legal(legal), .resp_rdata(resp_rdata),
    .resp_ready(resp_ready), .reg_req(reg_req), .reg_wr(reg_wr), .reg_c45(reg_c45),
    .reg_devad(reg_devad), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .err_timeout(err_timeout)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input logic [31:0] d, input bit lg, input int dly,
                         input logic [15:0] rdata, input bit e_req, input bit e_wr,
                         input bit e_c45, input logic [4:0] e_devad, input logic [15:0] e_addr,
                         input logic [15:0] e_wdata, input bit e_rdy, input logic [15:0] e_rd);
    req_data = d; legal = lg;
    req_phyaddr_done = 1'b1; @(negedge clk_25m); req_phyaddr_done = 1'b0;
    chk("phy_ready", resp_ready, 0);
    chk("phy_rdata", resp_rdata, 16'hFFFF);
    req_regaddr_done = 1'b1; @(negedge clk_25m); req_regaddr_done = 1'b0;
    if (!(e_req && !e_wr)) begin
      req_frame_done = 1'b1; @(negedge clk_25m); req_frame_done = 1'b0;
    end
    chk("req", reg_req, e_req);
    if (e_req) begin
      chk("wr", reg_wr, e_wr);
      chk("c45", reg_c45, e_c45);
      chk("devad", reg_devad, e_devad);
      chk("addr", reg_addr, e_addr);
      if (e_wr) chk("wdata", reg_wdata, e_wdata);
      if (dly < TIMEOUT) begin
        repeat (dly) @(negedge clk_25m);
        reg_rdata = rdata; reg_ack = 1'b1;
        @(negedge clk_25m); reg_ack = 1'b0;
        chk("req_after_ack", reg_req, 0);
        chk("no_timeout", err_timeout, 0);
      end else begin
        repeat (TIMEOUT - 1) @(negedge clk_25m);
        chk("req_held", reg_req, 1);
        @(negedge clk_25m);
        chk("req_abandoned", reg_req, 0);
        chk("err_timeout", err_timeout, 1);
      end
    end else begin
      repeat (2) @(negedge clk_25m);
      chk("req_idle", reg_req, 0);
    end
    chk("resp_ready", resp_ready, e_rdy);
    chk("resp_rdata", resp_rdata, e_rd);
    @(negedge clk_25m);
    chk("err_pulse_end", err_timeout, 0);
  endtask

  // Transaction-level reference: frame rules applied directly to the header fields.
  task automatic model_txn(input logic [31:0] d, input bit lg, input int dly, input logic [15:0] rdata);
    logic [1:0] st, op;
    bit rd, wr, ad, inc, c45, ackd;
    st = d[31:30]; op = d[29:28];
    rd  = lg && ((st == 2'b01 && op == 2'b10) || (st == 2'b00 && op[1]));
    wr  = lg && (st == 2'b01 || st == 2'b00) && op == 2'b01;
    ad  = lg && st == 2'b00 && op == 2'b00;
    inc = rd && st == 2'b00 && op == 2'b10;
    c45 = (st == 2'b00);
    ackd = dly < TIMEOUT;
    run_txn(d, lg, dly, rdata, rd || wr, wr, c45,
            c45 ? d[22:18] : d[27:23], c45 ? c45_m : {11'b0, d[22:18]}, d[15:0],
            rd, (rd && ackd) ? rdata : 16'hFFFF);
    if (ad) c45_m = d[15:0];
    if (inc && ackd) c45_m = c45_m + 16'd1;
  endtask

  typedef struct {
    logic [31:0] d; bit lg; int dly; logic [15:0] rdata;
    bit req; bit wr; bit c45; logic [4:0] devad; logic [15:0] addr; logic [15:0] wdata;
    bit rdy; logic [15:0] rd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0; enable = 1'b1; req_data = '0; legal = 1'b0;
    req_phyaddr_done = 1'b0; req_regaddr_done = 1'b0; req_frame_done = 1'b0;
    reg_rdata = '0; reg_ack = 1'b0; c45_m = 16'h0000;

    tbl[0]  = '{{2'b01,2'b10,5'd3,5'd2,2'b00,16'h0000}, 1, 3, 16'h1234, 1,0,0,5'd3, 16'h0002,16'h0000,1,16'h1234};
    tbl[1]  = '{{2'b00,2'b00,5'd0,5'd1,2'b00,16'h8000}, 1, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[2]  = '{{2'b00,2'b01,5'd0,5'd1,2'b00,16'hBEEF}, 1, 1, 16'h0000, 1,1,1,5'd1, 16'h8000,16'hBEEF,0,16'hFFFF};
    tbl[3]  = '{{2'b00,2'b11,5'd0,5'd7,2'b00,16'h0000}, 1, 0, 16'hA5A5, 1,0,1,5'd7, 16'h8000,16'h0000,1,16'hA5A5};
    tbl[4]  = '{{2'b00,2'b00,5'd0,5'd2,2'b00,16'hFFFF}, 1, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[5]  = '{{2'b00,2'b10,5'd0,5'd2,2'b00,16'h0000}, 1, 5, 16'h5555, 1,0,1,5'd2, 16'hFFFF,16'h0000,1,16'h5555};
    tbl[6]  = '{{2'b00,2'b10,5'd0,5'd2,2'b00,16'h0000}, 1,99, 16'h7777, 1,0,1,5'd2, 16'h0000,16'h0000,1,16'hFFFF};
    tbl[7]  = '{{2'b00,2'b11,5'd0,5'd2,2'b00,16'h0000}, 1,11, 16'h0101, 1,0,1,5'd2, 16'h0000,16'h0000,1,16'h0101};
    tbl[8]  = '{32'hFFFF_FFFF,                           0, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[9]  = '{{2'b01,2'b01,5'd31,5'd31,2'b00,16'hCAFE},0, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[10] = '{{2'b01,2'b01,5'd31,5'd31,2'b00,16'hCAFE},1,11, 16'h0000, 1,1,0,5'd31,16'h001F,16'hCAFE,0,16'hFFFF};
    tbl[11] = '{{2'b01,2'b00,5'd1,5'd1,2'b00,16'h1111}, 1, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[12] = '{{2'b10,2'b10,5'd1,5'd1,2'b00,16'h0000}, 1, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[13] = '{{2'b00,2'b01,5'd0,5'd3,2'b00,16'h1357}, 1,99, 16'h0000, 1,1,1,5'd3, 16'h0000,16'h1357,0,16'hFFFF};
    tbl[14] = '{{2'b00,2'b00,5'd0,5'd4,2'b00,16'h2468}, 1, 0, 16'h0000, 0,0,0,5'd0, 16'h0000,16'h0000,0,16'hFFFF};
    tbl[15] = '{{2'b00,2'b10,5'd0,5'd4,2'b00,16'h0000}, 1, 2, 16'h0F0F, 1,0,1,5'd4, 16'h2468,16'h0000,1,16'h0F0F};

    // Reset state
    repeat (2) @(negedge clk_25m);
    chk("rst_req", reg_req, 0);       chk("rst_wr", reg_wr, 0);
    chk("rst_c45", reg_c45, 0);       chk("rst_devad", reg_devad, 0);
    chk("rst_addr", reg_addr, 0);     chk("rst_wdata", reg_wdata, 0);
    chk("rst_rdata", resp_rdata, 16'hFFFF);
    chk("rst_ready", resp_ready, 0);  chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk_25m);

    for (int i = 0; i < 16; i++)
      run_txn(tbl[i].d, tbl[i].lg, tbl[i].dly, tbl[i].rdata, tbl[i].req, tbl[i].wr,
              tbl[i].c45, tbl[i].devad, tbl[i].addr, tbl[i].wdata, tbl[i].rdy, tbl[i].rd);

    // Reads during WR_WAIT: second overwrites first, issued the cycle after ack; then async reset
    legal = 1'b1;
    req_data = {2'b01,2'b01,5'd4,5'd1,2'b00,16'hAAAA};
    req_frame_done = 1'b1; @(negedge clk_25m); req_frame_done = 1'b0;
    chk("pend_wr_req", reg_req, 1);
    chk("pend_wr_wr", reg_wr, 1);
    req_data = {2'b01,2'b10,5'd4,5'd5,2'b00,16'h0000};
    req_regaddr_done = 1'b1; @(negedge clk_25m);
    req_data = {2'b01,2'b10,5'd4,5'd9,2'b00,16'h0000};
    @(negedge clk_25m); req_regaddr_done = 1'b0;
    chk("pend_still_wr", reg_wr, 1);
    reg_ack = 1'b1; @(negedge clk_25m); reg_ack = 1'b0;
    chk("pend_gap", reg_req, 0);
    @(negedge clk_25m);
    chk("pend_issue_req", reg_req, 1);
    chk("pend_issue_wr", reg_wr, 0);
    chk("pend_issue_addr", reg_addr, 16'h0009);
    chk("pend_issue_devad", reg_devad, 5'd4);
    chk("pre_rst_ready", resp_ready, 1);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_req", reg_req, 0);
    chk("arst_rdata", resp_rdata, 16'hFFFF);
    chk("arst_ready", resp_ready, 0);
    chk("arst_addr", reg_addr, 0);
    @(negedge clk_25m); rst_n = 1'b1; c45_m = 16'h0000;
    @(negedge clk_25m);

    // enable drop mid-read and with a queued read; c45_addr must survive
    model_txn({2'b00,2'b00,5'd0,5'd6,2'b00,16'h4321}, 1, 0, 16'h0000);
    req_data = {2'b00,2'b11,5'd0,5'd6,2'b00,16'h0000};
    req_regaddr_done = 1'b1; @(negedge clk_25m); req_regaddr_done = 1'b0;
    chk("en_rd_addr", reg_addr, 16'h4321);
    @(negedge clk_25m); enable = 1'b0; @(negedge clk_25m);
    chk("en_drop_req", reg_req, 0);
    chk("en_drop_ready", resp_ready, 0);
    enable = 1'b1;
    req_data = {2'b01,2'b01,5'd2,5'd3,2'b00,16'h5A5A};
    req_frame_done = 1'b1; @(negedge clk_25m); req_frame_done = 1'b0;
    chk("en_wr_req", reg_req, 1);
    req_data = {2'b01,2'b10,5'd2,5'd3,2'b00,16'h0000};
    req_regaddr_done = 1'b1; @(negedge clk_25m); req_regaddr_done = 1'b0;
    enable = 1'b0; @(negedge clk_25m);
    chk("en_drop_wr", reg_req, 0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25m);
      chk("en_pend_dropped", reg_req, 0);
    end
    model_txn({2'b00,2'b11,5'd0,5'd6,2'b00,16'h0000}, 1, 1, 16'h9876);

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      int r;
      d = $urandom;
      r = $urandom_range(0, 9);
      if (r < 4) d[31:30] = 2'b00;
      else if (r < 8) d[31:30] = 2'b01;
      model_txn(d, $urandom_range(0, 9) != 0, $urandom_range(0, 13), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
